comb_sweep_checker: RTL and testbench

//  Stimulus and check stage that wraps complex_comb_logic. It sits upstream, driving a,b,c,d, and

---
 rtl/comb_sweep_pkg.sv | 22 ++
 rtl/comb_sweep_checker.sv | 128 ++++++++++++
 tb/tb_comb_sweep_checker.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the combinational-netlist sweep checker.
package comb_sweep_pkg;

  localparam int VEC_W = 4;
  localparam int ERR_W = 5;

  // {x,y,z} for vector v lives at bits [3*v+2:3*v]
  localparam logic [47:0]      GOLDEN_DEFAULT = 48'o0007122512251664;
  localparam logic [VEC_W-1:0] VEC_LAST       = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  function automatic logic [2:0] golden_bits(input logic [47:0] g, input logic [VEC_W-1:0] v);
    return g[3*int'(v) +: 3];
  endfunction

endpackage

// File: rtl/comb_sweep_checker.sv
// Walks all 16 input vectors of the netlist under test, samples {x,y,z} after a settle
// window and counts mismatches against a golden table.
module comb_sweep_checker
  import comb_sweep_pkg::*;
#(
  parameter logic [47:0] GOLDEN = GOLDEN_DEFAULT,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  input  logic             x_i,
  input  logic             y_i,
  input  logic             z_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [VEC_W-1:0] first_fail_vec_o,
  output logic             first_fail_valid_o
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [3:0]         wait_q, wait_d;
  logic [2:0]         cap_q, cap_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   ffv_q, ffv_d;
  logic               ffval_q, ffval_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mismatch;

  assign mismatch = |(cap_q ^ golden_bits(GOLDEN, vec_q));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    cap_d   = cap_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          vec_d   = '0;
          wait_d  = SETTLE_C;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          cap_d   = {x_i, y_i, z_i};
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end
        // Terminating on the last vector keeps vec from ever wrapping.
        if (vec_q == VEC_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          wait_d  = SETTLE_C;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      cap_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {a_o, b_o, c_o, d_o} = vec_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = done_q && (err_q == '0);
  assign err_count_o        = err_q;
  assign first_fail_vec_o   = ffv_q;
  assign first_fail_valid_o = ffval_q;

endmodule

// File: tb/tb_comb_sweep_checker.sv
// Bench: three checkers (SETTLE 0/1/3) each wrapped around a behavioural netlist model
// whose fault mode is selectable.
module tb_comb_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = 3'b000;
  int         fault_mode = 0;
  int         checks = 0;
  int         failures = 0;

  logic       a_s [3];
  logic       b_s [3];
  logic       c_s [3];
  logic       d_s [3];
  logic       x_s [3];
  logic       y_s [3];
  logic       z_s [3];
  logic       busy_s [3];
  logic       done_s [3];
  logic       pass_s [3];
  logic [4:0] err_s [3];
  logic [3:0] ffv_s [3];
  logic       ffval_s [3];
  logic [3:0] vec_s [3];

  always #5 clk = ~clk;

  // Netlist model: hand-decoded golden table plus injectable faults.
  function automatic logic [2:0] model(input logic [3:0] v, input int mode);
    logic [2:0] r;
    case (v)
      4'd0: r = 3'd4;  4'd1: r = 3'd6;  4'd2: r = 3'd6;  4'd3: r = 3'd1;
      4'd4: r = 3'd5;  4'd5: r = 3'd2;  4'd6: r = 3'd2;  4'd7: r = 3'd1;
      4'd8: r = 3'd5;  4'd9: r = 3'd2;  4'd10: r = 3'd2; 4'd11: r = 3'd1;
      4'd12: r = 3'd7; default: r = 3'd0;
    endcase
    if (mode == 1) r[2] = 1'b0;
    if (mode == 2) r[0] = ~r[0];
    if (mode == 3 && v == 4'd13) r[2] = 1'b1;
    return r;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_model
    assign vec_s[i] = {a_s[i], b_s[i], c_s[i], d_s[i]};
    assign {x_s[i], y_s[i], z_s[i]} = model(vec_s[i], fault_mode);
  end

  comb_sweep_checker #(.SETTLE(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]),
    .a_o(a_s[0]), .b_o(b_s[0]), .c_o(c_s[0]), .d_o(d_s[0]),
    .x_i(x_s[0]), .y_i(y_s[0]), .z_i(z_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .pass_o(pass_s[0]),
    .err_count_o(err_s[0]), .first_fail_vec_o(ffv_s[0]), .first_fail_valid_o(ffval_s[0])
  );

  comb_sweep_checker #(.SETTLE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]),
    .a_o(a_s[1]), .b_o(b_s[1]), .c_o(c_s[1]), .d_o(d_s[1]),
    .x_i(x_s[1]), .y_i(y_s[1]), .z_i(z_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .pass_o(pass_s[1]),
    .err_count_o(err_s[1]), .first_fail_vec_o(ffv_s[1]), .first_fail_valid_o(ffval_s[1])
  );

  comb_sweep_checker #(.SETTLE(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]),
    .a_o(a_s[2]), .b_o(b_s[2]), .c_o(c_s[2]), .d_o(d_s[2]),
    .x_i(x_s[2]), .y_i(y_s[2]), .z_i(z_s[2]),
    .busy_o(busy_s[2]), .done_o(done_s[2]), .pass_o(pass_s[2]),
    .err_count_o(err_s[2]), .first_fail_vec_o(ffv_s[2]), .first_fail_valid_o(ffval_s[2])
  );

  // Start a sweep on instance sel and follow it until done; after edge k the stimulus
  // vector must be k/(settle+2). Optional start pulses every pulse_every cycles mid-sweep.
  task automatic run_sweep(input int sel, input int settle, input int pulse_every,
                           output int cycles, output int vec_bad,
                           output logic done0, output logic [4:0] err0, output logic busy0);
    bit got = 0;
    cycles  = -1;
    vec_bad = 0;
    @(negedge clk);
    start[sel] = 1'b1;
    @(posedge clk);
    #1;
    start[sel] = 1'b0;
    done0 = done_s[sel];
    err0  = err_s[sel];
    busy0 = busy_s[sel];
    for (int k = 1; k <= 400 && !got; k++) begin
      @(posedge clk);
      #1;
      start[sel] = 1'b0;
      if (done_s[sel]) begin
        got    = 1;
        cycles = k;
      end else begin
        if (int'(vec_s[sel]) != k / (settle + 2)) vec_bad++;
        if (pulse_every > 0 && (k % pulse_every) == 0) start[sel] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (vec_s[1] !== 4'd0) begin failures++; $display("FAIL reset_abcd got=%0d exp=0", vec_s[1]); end
    checks++; if (busy_s[1] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_s[1]); end
    checks++; if (done_s[1] !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done_s[1]); end
    checks++; if (pass_s[1] !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0b exp=0", pass_s[1]); end
    checks++; if (err_s[1] !== 5'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_s[1]); end
    checks++; if (ffval_s[1] !== 1'b0) begin failures++; $display("FAIL reset_ffvalid got=%0b exp=0", ffval_s[1]); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_golden();
    int cyc, bad; logic d0, b0; logic [4:0] e0;
    fault_mode = 0;
    run_sweep(1, 1, 0, cyc, bad, d0, e0, b0);
    checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL golden_busy_after_start got=%0b exp=1", b0); end
    checks++; if (cyc != 48) begin failures++; $display("FAIL golden_cycles got=%0d exp=48", cyc); end
    checks++; if (bad != 0) begin failures++; $display("FAIL golden_vec_seq got=%0d bad exp=0", bad); end
    checks++; if (err_s[1] !== 5'd0) begin failures++; $display("FAIL golden_err got=%0d exp=0", err_s[1]); end
    checks++; if (pass_s[1] !== 1'b1) begin failures++; $display("FAIL golden_pass got=%0b exp=1", pass_s[1]); end
    checks++; if (ffval_s[1] !== 1'b0) begin failures++; $display("FAIL golden_ffvalid got=%0b exp=0", ffval_s[1]); end
    checks++; if (busy_s[1] !== 1'b0) begin failures++; $display("FAIL golden_busy_done got=%0b exp=0", busy_s[1]); end
  endtask

  task automatic test_x_stuck();
    int cyc, bad; logic d0, b0; logic [4:0] e0;
    fault_mode = 1;
    run_sweep(1, 1, 0, cyc, bad, d0, e0, b0);
    checks++; if (err_s[1] !== 5'd6) begin failures++; $display("FAIL xstuck_err got=%0d exp=6", err_s[1]); end
    checks++; if (ffv_s[1] !== 4'd0) begin failures++; $display("FAIL xstuck_ffvec got=%0d exp=0", ffv_s[1]); end
    checks++; if (ffval_s[1] !== 1'b1) begin failures++; $display("FAIL xstuck_ffvalid got=%0b exp=1", ffval_s[1]); end
    checks++; if (pass_s[1] !== 1'b0) begin failures++; $display("FAIL xstuck_pass got=%0b exp=0", pass_s[1]); end
  endtask

  task automatic test_start_in_done();
    int cyc, bad; logic d0, b0; logic [4:0] e0;
    fault_mode = 0;
    run_sweep(1, 1, 0, cyc, bad, d0, e0, b0);
    checks++; if (d0 !== 1'b0) begin failures++; $display("FAIL restart_done_clr got=%0b exp=0", d0); end
    checks++; if (e0 !== 5'd0) begin failures++; $display("FAIL restart_err_clr got=%0d exp=0", e0); end
    checks++; if (cyc != 48) begin failures++; $display("FAIL restart_cycles got=%0d exp=48", cyc); end
    checks++; if (pass_s[1] !== 1'b1) begin failures++; $display("FAIL restart_pass got=%0b exp=1", pass_s[1]); end
  endtask

  task automatic test_z_inv_and_v13();
    int cyc, bad; logic d0, b0; logic [4:0] e0;
    fault_mode = 2;
    run_sweep(1, 1, 0, cyc, bad, d0, e0, b0);
    checks++; if (err_s[1] !== 5'd16) begin failures++; $display("FAIL zinv_err got=%0d exp=16", err_s[1]); end
    checks++; if (ffv_s[1] !== 4'd0) begin failures++; $display("FAIL zinv_ffvec got=%0d exp=0", ffv_s[1]); end
    fault_mode = 3;
    run_sweep(1, 1, 0, cyc, bad, d0, e0, b0);
    checks++; if (err_s[1] !== 5'd1) begin failures++; $display("FAIL v13_err got=%0d exp=1", err_s[1]); end
    checks++; if (ffv_s[1] !== 4'd13) begin failures++; $display("FAIL v13_ffvec got=%0d exp=13", ffv_s[1]); end
    checks++; if (ffval_s[1] !== 1'b1) begin failures++; $display("FAIL v13_ffvalid got=%0b exp=1", ffval_s[1]); end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, bad; logic d0, b0; logic [4:0] e0;
    fault_mode = 1;
    @(negedge clk);
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    // vectors 0..5 checked so far; x stuck-at-0 fails 0,1,2,4
    checks++; if (err_s[1] !== 5'd4) begin failures++; $display("FAIL midrst_err_before got=%0d exp=4", err_s[1]); end
    checks++; if (vec_s[1] !== 4'd6) begin failures++; $display("FAIL midrst_vec_before got=%0d exp=6", vec_s[1]); end
    rst = 1'b1;
    #1;
    checks++; if (vec_s[1] !== 4'd0) begin failures++; $display("FAIL midrst_abcd got=%0d exp=0", vec_s[1]); end
    checks++; if (busy_s[1] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy_s[1]); end
    checks++; if (err_s[1] !== 5'd0) begin failures++; $display("FAIL midrst_err got=%0d exp=0", err_s[1]); end
    checks++; if (ffval_s[1] !== 1'b0) begin failures++; $display("FAIL midrst_ffvalid got=%0b exp=0", ffval_s[1]); end
    checks++; if (done_s[1] !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", done_s[1]); end
    @(negedge clk);
    rst = 1'b0;
    fault_mode = 0;
    run_sweep(1, 1, 0, cyc, bad, d0, e0, b0);
    checks++; if (cyc != 48) begin failures++; $display("FAIL midrst_resweep_cycles got=%0d exp=48", cyc); end
    checks++; if (pass_s[1] !== 1'b1) begin failures++; $display("FAIL midrst_resweep_pass got=%0b exp=1", pass_s[1]); end
  endtask

  task automatic test_start_while_busy();
    int cyc, bad; logic d0, b0; logic [4:0] e0;
    fault_mode = 0;
    run_sweep(1, 1, 7, cyc, bad, d0, e0, b0);
    checks++; if (cyc != 48) begin failures++; $display("FAIL busy_start_cycles got=%0d exp=48", cyc); end
    checks++; if (bad != 0) begin failures++; $display("FAIL busy_start_vec_seq got=%0d bad exp=0", bad); end
  endtask

  task automatic test_settle_variants();
    int cyc, bad; logic d0, b0; logic [4:0] e0;
    fault_mode = 0;
    run_sweep(0, 0, 0, cyc, bad, d0, e0, b0);
    checks++; if (cyc != 32) begin failures++; $display("FAIL settle0_cycles got=%0d exp=32", cyc); end
    checks++; if (bad != 0) begin failures++; $display("FAIL settle0_vec_seq got=%0d bad exp=0", bad); end
    checks++; if (pass_s[0] !== 1'b1) begin failures++; $display("FAIL settle0_pass got=%0b exp=1", pass_s[0]); end
    run_sweep(2, 3, 0, cyc, bad, d0, e0, b0);
    checks++; if (cyc != 80) begin failures++; $display("FAIL settle3_cycles got=%0d exp=80", cyc); end
    checks++; if (bad != 0) begin failures++; $display("FAIL settle3_vec_seq got=%0d bad exp=0", bad); end
    checks++; if (pass_s[2] !== 1'b1) begin failures++; $display("FAIL settle3_pass got=%0b exp=1", pass_s[2]); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_x_stuck();
    test_start_in_done();
    test_z_inv_and_v13();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_settle_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
